// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the serial pattern detector.
// Holds the fill-state encoding and the saturating increment used by the match counter.
package seq_det_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    ARMED   = 2'd2
  } fill_state_t;

  // Increment cnt by one, holding at the all-ones value of a 'width'-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input int unsigned width);
    logic [31:0] max_v;
    if (width >= 32'd32) begin
      max_v = '1;
    end else begin
      max_v = (32'd1 << width) - 32'd1;
    end
    if (cnt == max_v) begin
      return cnt;
    end else begin
      return cnt + 32'd1;
    end
  endfunction

endpackage

// File: rtl/seq_match_counter.sv
// Saturating match counter with a registered all-ones flag.
// Clear has priority over increment; the flag tracks the value the counter is loaded with.
module seq_match_counter
  import seq_det_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  logic [CNT_W-1:0] count_d, count_q;
  logic             sat_d, sat_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      count_d = CNT_W'(sat_inc(32'(count_q), CNT_W));
    end else begin
      count_d = count_q;
    end
    sat_d = (count_d == {CNT_W{1'b1}});
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      sat_q   <= sat_d;
    end
  end

  assign count = count_q;
  assign sat   = sat_q;

endmodule

// File: rtl/seq_pattern_detector.sv
// Parametrised serial bit-pattern detector: history shift register, fill FSM,
// comparator and registered match pulse, with a saturating match counter.
module seq_pattern_detector
  import seq_det_pkg::*;
#(
  parameter int                 PAT_LEN = 3,
  parameter logic [PAT_LEN-1:0] PATTERN = 3'b101,
  parameter bit                 OVERLAP = 1'b1,
  parameter int                 CNT_W   = 8
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iEN,
  input  logic             iIN,
  input  logic             iCLR,
  output logic             oMATCH,
  output logic [CNT_W-1:0] oCOUNT,
  output logic             oCOUNT_SAT
);

  localparam int FW = $clog2(PAT_LEN + 1);
  localparam logic [FW-1:0] FULL = FW'(PAT_LEN);

  logic [PAT_LEN-1:0] hist_d, hist_q, hist_n;
  logic [FW-1:0]      fill_d, fill_q, fill_n;
  fill_state_t        state_d, state_q;
  logic               match_d, match_q;
  logic               hit;

  always_comb begin
    hist_d  = hist_q;
    fill_d  = fill_q;
    match_d = 1'b0;
    hit     = 1'b0;
    hist_n  = {hist_q[PAT_LEN-2:0], iIN};
    if (state_q == ARMED) begin
      fill_n = FULL;
    end else begin
      fill_n = fill_q + FW'(1);
    end
    if (iCLR) begin
      hist_d = '0;
      fill_d = '0;
    end else if (iEN) begin
      hit     = (fill_n == FULL) && (hist_n == PATTERN);
      hist_d  = hist_n;
      match_d = hit;
      // Non-overlapping mode forgets the bits that formed the match.
      if (hit && !OVERLAP) begin
        fill_d = '0;
      end else begin
        fill_d = fill_n;
      end
    end else begin
      hist_d = hist_q;
      fill_d = fill_q;
    end
    if (fill_d == '0) begin
      state_d = EMPTY;
    end else if (fill_d == FULL) begin
      state_d = ARMED;
    end else begin
      state_d = FILLING;
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      hist_q  <= '0;
      fill_q  <= '0;
      state_q <= EMPTY;
      match_q <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      state_q <= state_d;
      match_q <= match_d;
    end
  end

  seq_match_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .iCLK (iCLK),
    .iRST (iRST),
    .inc  (hit),
    .clr  (iCLR),
    .count(oCOUNT),
    .sat  (oCOUNT_SAT)
  );

  assign oMATCH = match_q;

endmodule
